// File: rtl/fetch_stage.sv
// Instruction fetch stage for microRISC: PC, single-outstanding imem requests,
// 1-entry skid buffer and IF/ID register. Define FETCH_PERF_EN for perf counters.
module fetch_stage #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [15:0]     imem_rsp_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            id_valid,
    output logic [15:0]     id_instr,
    output logic [PC_W-1:0] id_pc,
    output logic [PC_W-1:0] id_pc_plus2,
    output logic [3:0]      id_opcode,
    output logic [2:0]      id_funct
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t          state, state_n;
    logic [PC_W-1:0] pc;
    logic            buf_valid;
    logic [15:0]     buf_instr;
    logic [PC_W-1:0] buf_pc;
    logic [15:0]     id_instr_q;

    logic rsp_take;
    logic to_id;
    logic to_buf;

    assign imem_req_valid = !rst && (state == IDLE) && !buf_valid && !redirect_valid;
    assign imem_addr      = pc;

    // A response is only consumed while waiting; redirect discards it.
    assign rsp_take = (state == WAIT) && imem_rsp_valid && !redirect_valid;
    assign to_id    = rsp_take && !stall;
    assign to_buf   = rsp_take && stall;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // NOTE: state_n gets a default before any branch so no latch is inferred.
    always_comb begin
        state_n = state;
        if (redirect_valid) begin
            case (state)
                WAIT:    state_n = imem_rsp_valid ? IDLE : DROP;
                DROP:    state_n = DROP;
                default: state_n = IDLE;
            endcase
        end else begin
            case (state)
                IDLE:    if (imem_req_valid && imem_req_ready) state_n = WAIT;
                WAIT:    if (imem_rsp_valid) state_n = IDLE;
                DROP:    if (imem_rsp_valid) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            buf_valid  <= 1'b0;
            id_valid   <= 1'b0;
            id_instr_q <= 16'h0000;
            id_pc      <= RESET_PC;
        end else if (redirect_valid) begin
            pc        <= redirect_pc;
            buf_valid <= 1'b0;
            id_valid  <= 1'b0;
        end else begin
            if (rsp_take) pc <= pc + PC_W'(2);

            if (to_buf)                 buf_valid <= 1'b1;
            else if (buf_valid && !stall) buf_valid <= 1'b0;

            // Unstalled IF/ID advances: new response, drained buffer, or bubble.
            if (!stall) begin
                if (to_id) begin
                    id_valid   <= 1'b1;
                    id_instr_q <= imem_rsp_data;
                    id_pc      <= pc;
                end else if (buf_valid) begin
                    id_valid   <= 1'b1;
                    id_instr_q <= buf_instr;
                    id_pc      <= buf_pc;
                end else begin
                    id_valid   <= 1'b0;
                end
            end
        end
    end

    // NOTE: buffer payload has no reset; buf_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (to_buf && !rst) begin
            buf_instr <= imem_rsp_data;
            buf_pc    <= pc;
        end
    end

    assign id_instr    = id_valid ? id_instr_q : 16'h0000;
    assign id_pc_plus2 = id_pc + PC_W'(2);
    assign id_opcode   = id_instr[15:12];
    assign id_funct    = id_instr[2:0];

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (rsp_take)          perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall && id_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redirect_valid)    perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; drives imem by hand per scenario.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_plus2;
    logic [3:0]  id_opcode;
    logic [2:0]  id_funct;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_stage #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus2    (id_pc_plus2),
        .id_opcode      (id_opcode),
        .id_funct       (id_funct)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    // Advance past the next rising edge; inputs then change away from the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Accept one request and return data one cycle later.
    task automatic do_fetch(input logic [15:0] data);
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        cyc();
        imem_rsp_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        cyc(); cyc();
        tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL rst_id_valid got %h want 0", id_valid); end
        tests++; if (id_instr !== 16'h0000) begin fails++; $display("FAIL rst_id_instr got %h want 0000", id_instr); end
        tests++; if (id_pc !== 16'h0000) begin fails++; $display("FAIL rst_id_pc got %h want 0000", id_pc); end
        tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid got %h want 0", imem_req_valid); end
        rst = 1'b0; #1;
        tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 16'h0000) begin fails++;
            $display("FAIL post_rst_req got v=%h a=%h want v=1 a=0000", imem_req_valid, imem_addr); end
    endtask

    task automatic test_basic();
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 16'h1234; #1;
        tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL wait_req_valid got %h want 0", imem_req_valid); end
        cyc();
        imem_rsp_valid = 1'b0; #1;
        tests++; if (id_valid !== 1'b1 || id_instr !== 16'h1234 || id_pc !== 16'h0000) begin fails++;
            $display("FAIL first_instr got v=%h i=%h pc=%h want v=1 i=1234 pc=0000", id_valid, id_instr, id_pc); end
        tests++; if (id_opcode !== 4'h1 || id_funct !== 3'b100 || id_pc_plus2 !== 16'h0002) begin fails++;
            $display("FAIL first_fields got op=%h fn=%h p2=%h want op=1 fn=4 p2=0002", id_opcode, id_funct, id_pc_plus2); end
        tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 16'h0002) begin fails++;
            $display("FAIL second_req got v=%h a=%h want v=1 a=0002", imem_req_valid, imem_addr); end
        do_fetch(16'h5678);
        tests++; if (id_valid !== 1'b1 || id_instr !== 16'h5678 || id_pc !== 16'h0002) begin fails++;
            $display("FAIL second_instr got v=%h i=%h pc=%h want v=1 i=5678 pc=0002", id_valid, id_instr, id_pc); end
    endtask

    task automatic test_stall();
        stall = 1'b1; imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 16'hABCD;
        cyc();
        imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; #1;
        tests++; if (id_valid !== 1'b1 || id_instr !== 16'h5678 || id_pc !== 16'h0002) begin fails++;
            $display("FAIL stall_hold got v=%h i=%h pc=%h want v=1 i=5678 pc=0002", id_valid, id_instr, id_pc); end
        tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL stall_no_req got %h want 0", imem_req_valid); end
        imem_req_ready = 1'b0;
        cyc();
        tests++; if (id_instr !== 16'h5678 || imem_req_valid !== 1'b0) begin fails++;
            $display("FAIL stall_hold2 got i=%h rv=%h want i=5678 rv=0", id_instr, imem_req_valid); end
        stall = 1'b0;
        cyc();
        tests++; if (id_valid !== 1'b1 || id_instr !== 16'hABCD || id_pc !== 16'h0004) begin fails++;
            $display("FAIL drain got v=%h i=%h pc=%h want v=1 i=abcd pc=0004", id_valid, id_instr, id_pc); end
        tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 16'h0006) begin fails++;
            $display("FAIL drain_next_req got v=%h a=%h want v=1 a=0006", imem_req_valid, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0040;
        cyc();
        redirect_valid = 1'b0;
        cyc(); cyc();
        tests++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin fails++;
            $display("FAIL drop_wait got rv=%h v=%h want rv=0 v=0", imem_req_valid, id_valid); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 16'hDEAD;
        cyc();
        imem_rsp_valid = 1'b0; #1;
        tests++; if (id_valid !== 1'b0 || id_instr !== 16'h0000) begin fails++;
            $display("FAIL drop_discard got v=%h i=%h want v=0 i=0000", id_valid, id_instr); end
        tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 16'h0040) begin fails++;
            $display("FAIL drop_restart got v=%h a=%h want v=1 a=0040", imem_req_valid, imem_addr); end
    endtask

    task automatic test_redirect_same_cycle();
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 16'h1111;
        redirect_valid = 1'b1; redirect_pc = 16'h0080; #1;
        tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL redir_mask got %h want 0", imem_req_valid); end
        cyc();
        imem_rsp_valid = 1'b0; redirect_valid = 1'b0; #1;
        tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 16'h0080 || id_valid !== 1'b0) begin fails++;
            $display("FAIL redir_same got rv=%h a=%h v=%h want rv=1 a=0080 v=0", imem_req_valid, imem_addr, id_valid); end
    endtask

    task automatic test_wrap_and_mid_reset();
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        cyc();
        redirect_valid = 1'b0; #1;
        do_fetch(16'h2ABC);
        tests++; if (id_pc !== 16'hFFFE || id_instr !== 16'h2ABC || id_pc_plus2 !== 16'h0000) begin fails++;
            $display("FAIL wrap_id got pc=%h i=%h p2=%h want pc=fffe i=2abc p2=0000", id_pc, id_instr, id_pc_plus2); end
        tests++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL wrap_pc got %h want 0000", imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 16'h0100;
        cyc();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0; #1;
        tests++; if (imem_addr !== 16'h0000 || id_valid !== 1'b0 || imem_req_valid !== 1'b1) begin fails++;
            $display("FAIL mid_rst got a=%h v=%h rv=%h want a=0000 v=0 rv=1", imem_addr, id_valid, imem_req_valid); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 16'h7777;
        cyc();
        imem_rsp_valid = 1'b0; #1;
        tests++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 16'h0000) begin fails++;
            $display("FAIL late_rsp got v=%h rv=%h a=%h want v=0 rv=1 a=0000", id_valid, imem_req_valid, imem_addr); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        cyc();
        rst = 1'b0; #1;
        tests++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin fails++;
            $display("FAIL perf_rst got %0d/%0d/%0d want 0/0/0", perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt); end
        do_fetch(16'h0001);
        stall = 1'b1;
        do_fetch(16'h0002);
        cyc();
        stall = 1'b0;
        cyc();
        do_fetch(16'h0003);
        do_fetch(16'h0004);
        redirect_valid = 1'b1; redirect_pc = 16'h0200;
        cyc();
        redirect_valid = 1'b0; #1;
        tests++; if (perf_fetch_cnt !== 32'd4 || perf_stall_cnt !== 32'd3 || perf_flush_cnt !== 32'd1) begin fails++;
            $display("FAIL perf_counts got %0d/%0d/%0d want 4/3/1", perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_wrap_and_mid_reset();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
